// File: rtl/match_event_recorder.sv
// match_event_recorder: timestamps "101" detector match pulses into a FWFT FIFO drained over valid/ready,
// with wrapping match counter, saturating drop counter and sticky overflow flag.
module match_event_recorder #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             z,
    input  logic             en,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TS_W-1:0]  out_ts,
    output logic [AW:0]      level,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow
);
    logic [TS_W-1:0]  r_ts;
    logic [TS_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_level;
    logic [CNT_W-1:0] r_match;
    logic [CNT_W-1:0] r_drop;
    logic             r_ovf;
    logic             w_ev;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic             w_drop_inc;
    always_comb begin
        w_ev       = z && en && !clr;
        w_pop      = out_valid && out_ready;
        w_full     = r_level == (AW+1)'(DEPTH);
        // a full FIFO still accepts when the head leaves in the same cycle
        w_push     = w_ev && (!w_full || w_pop);
        w_drop     = w_ev && !w_push;
        w_drop_inc = r_drop != '1;
    end
    always_ff @(posedge clk) begin
        if (reset)
            r_ts <= '0;
        else
            r_ts <= r_ts + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= r_ts;
    end
    // pointer width equals log2(DEPTH), so the natural binary wrap is the modulo-DEPTH wrap
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_match <= '0;
            r_drop  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_ev)
                r_match <= r_match + 1'b1;
            if (w_drop) begin
                r_drop <= r_drop + CNT_W'(w_drop_inc);
                r_ovf  <= 1'b1;
            end
        end
    end
    always_comb begin
        out_valid = r_level != '0;
        out_ts    = out_valid ? r_mem[r_rp] : '0;
        level     = r_level;
        match_cnt = r_match;
        drop_cnt  = r_drop;
        overflow  = r_ovf;
    end
endmodule
